// File: rtl/lif_aer_pkg.sv
// lif_aer_pkg: shared FSM states and AER word layout for the spike transmitter
package lif_aer_pkg;
  typedef enum logic [2:0] {IDLE, PICK, SETUP, REQ, RELEASE} state_t;
  localparam int EOS_BIT = 7;
  localparam int TS_LSB = 3;
  localparam int ADDR_W = 3;
  typedef struct packed {
    logic eos;
    logic [EOS_BIT-TS_LSB-1:0] ts;
    logic [ADDR_W-1:0] addr;
  } aer_word_t;
endpackage

// File: rtl/lif_vec_fifo.sv
// lif_vec_fifo: synchronous FIFO of {spike vector, timestamp} entries with wrap-bit pointers
module lif_vec_fifo #(
  parameter int W = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (push) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(push);
      rp <= rp + (AW+1)'(pop);
    end
endmodule

// File: rtl/lif_aer_tx.sv
// lif_aer_tx: buffers per-step spike vectors and sends each set bit as an AER word over four-phase req/ack
module lif_aer_tx
  import lif_aer_pkg::*;
#(
  parameter int N_NEURONS = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [N_NEURONS-1:0] spike_vec,
  input  logic                 spike_valid,
  output logic                 spike_ready,
  output logic [7:0]           aer_data,
  output logic                 aer_req,
  input  logic                 aer_ack,
  output logic                 busy,
  output logic                 overflow
);
  localparam int FW = N_NEURONS + TS_W;
  state_t state, state_n;
  logic [N_NEURONS-1:0] vec, vec_n, rest;
  logic [TS_W-1:0] ts, wts, wts_n;
  logic [ADDR_W-1:0] idx;
  logic [FW-1:0] head;
  aer_word_t word, word_n;
  logic req_n, ack_s1, ack_s2, full, empty, push, pop;
  assign spike_ready = ena && !full;
  assign push = spike_valid && spike_ready;
  assign pop = ena && state == IDLE && !empty;
  assign busy = state != IDLE || !empty;
  assign aer_data = word;
  assign rest = vec & (vec - N_NEURONS'(1));
  lif_vec_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din({spike_vec, ts}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    idx = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--)
      if (vec[i]) idx = ADDR_W'(i);
  end
  always_comb begin
    state_n = state;
    vec_n = vec;
    wts_n = wts;
    word_n = word;
    req_n = aer_req;
    case (state)
      IDLE: if (!empty) begin
        state_n = PICK;
        {vec_n, wts_n} = head;
      end
      PICK: if (vec == '0) state_n = IDLE;
      else begin
        word_n = {rest == '0, wts, idx};
        vec_n = rest;
        state_n = SETUP;
      end
      SETUP: begin
        req_n = 1'b1;
        state_n = REQ;
      end
      REQ: if (ack_s2) begin
        req_n = 1'b0;
        state_n = RELEASE;
      end
      RELEASE: if (!ack_s2) state_n = vec != '0 ? PICK : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      ack_s1 <= aer_ack;
      ack_s2 <= ack_s1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      vec <= '0;
      wts <= '0;
      word <= '0;
      aer_req <= 1'b0;
      ts <= '0;
      overflow <= 1'b0;
    end else if (ena) begin
      state <= state_n;
      vec <= vec_n;
      wts <= wts_n;
      word <= word_n;
      aer_req <= req_n;
      ts <= ts + TS_W'(spike_valid);
      overflow <= overflow | (spike_valid && full);
    end
endmodule

// File: tb/tb_lif_aer_tx.sv
// tb_lif_aer_tx: directed and randomized checks of lif_aer_tx against a queue-of-expected-words model
module tb_lif_aer_tx;
  logic clk, rst_n, ena, spike_valid, aer_ack;
  logic [7:0] spike_vec, aer_data;
  logic spike_ready, aer_req, busy, overflow;
  int n_tests = 0;
  int n_fail = 0;
  logic [3:0] m_ts;
  logic [7:0] exp_q[$];
  lif_aer_tx dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .spike_vec(spike_vec),
    .spike_valid(spike_valid),
    .spike_ready(spike_ready),
    .aer_data(aer_data),
    .aer_req(aer_req),
    .aer_ack(aer_ack),
    .busy(busy),
    .overflow(overflow)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [7:0] v, input logic acc);
    logic [7:0] w;
    chk("spike_ready", spike_ready, acc);
    spike_vec = v;
    spike_valid = 1'b1;
    tick();
    spike_valid = 1'b0;
    if (acc)
      for (int i = 0; i < 8; i++)
        if (v[i]) begin
          w[7] = (v >> (i + 1)) == 8'h00;
          w[6:3] = m_ts;
          w[2:0] = 3'(i);
          exp_q.push_back(w);
        end
    m_ts = m_ts + 4'd1;
  endtask
  task automatic wait_req();
    int n = 0;
    while (!aer_req && n < 40) begin
      tick();
      n++;
    end
    chk("req_rise", aer_req, 1);
  endtask
  task automatic recv(input int dly, output logic [7:0] d);
    logic [7:0] e;
    wait_req();
    d = aer_data;
    e = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
    chk("aer_word", d, e);
    repeat (dly) begin
      tick();
      chk("req_hold", aer_req, 1);
      chk("data_hold", aer_data, d);
    end
    aer_ack = 1'b1;
    repeat (2) begin
      tick();
      chk("req_wait_sync", aer_req, 1);
    end
    tick();
    chk("req_fall", aer_req, 0);
    chk("data_stable", aer_data, d);
    aer_ack = 1'b0;
    repeat (2) begin
      tick();
      chk("release_hold", {aer_req, aer_data}, {1'b0, d});
    end
  endtask
  task automatic drain();
    logic [7:0] d;
    while (exp_q.size() != 0) recv(int'($urandom_range(0, 3)), d);
  endtask
  task automatic settle();
    repeat (3) tick();
    chk("idle_busy", busy, 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    m_ts = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    logic [7:0] d;
    logic [3:0] ts5;
    rst_n = 1'b0;
    ena = 1'b1;
    spike_valid = 1'b0;
    spike_vec = '0;
    aer_ack = 1'b0;
    m_ts = '0;
    #1;
    chk("rst_req", aer_req, 0);
    chk("rst_data", aer_data, 8'h00);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", spike_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    push(8'b1000_0101, 1'b1);
    tick();
    chk("lat_e1", aer_req, 0);
    tick();
    chk("lat_e2", aer_req, 0);
    tick();
    chk("lat_e3", aer_req, 1);
    recv(0, d);
    chk("first_word", d, 8'h00);
    recv(0, d);
    chk("second_word", d, 8'h02);
    recv(0, d);
    chk("third_word", d, 8'h87);
    settle();
    do_reset();
    push(8'h00, 1'b1);
    push(8'h01, 1'b1);
    recv(0, d);
    chk("zero_then_one", d, 8'h88);
    settle();
    for (int k = 0; k < 6; k++) begin
      if (k == 4) ts5 = m_ts;
      push(8'($urandom_range(1, 255)), k < 5);
      if (k == 4) chk("no_overflow_yet", overflow, 0);
    end
    chk("overflow_set", overflow, 1);
    chk("ready_full", spike_ready, 0);
    recv(10, d);
    drain();
    push(8'h01, 1'b1);
    recv(0, d);
    chk("skipped_ts", d[6:3], ts5 + 4'd2);
    chk("overflow_sticky", overflow, 1);
    settle();
    push(8'hff, 1'b1);
    wait_req();
    rst_n = 1'b0;
    #1;
    chk("arst_req", aer_req, 0);
    chk("arst_data", aer_data, 8'h00);
    chk("arst_busy", busy, 0);
    chk("arst_overflow", overflow, 0);
    exp_q.delete();
    m_ts = '0;
    tick();
    rst_n = 1'b1;
    tick();
    push(8'h06, 1'b1);
    wait_req();
    d = aer_data;
    chk("ena_word", d, exp_q.pop_front());
    ena = 1'b0;
    aer_ack = 1'b1;
    spike_valid = 1'b1;
    spike_vec = 8'hff;
    repeat (5) begin
      tick();
      chk("frz_req", aer_req, 1);
      chk("frz_data", aer_data, d);
      chk("frz_ready", spike_ready, 0);
      chk("frz_busy", busy, 1);
    end
    spike_valid = 1'b0;
    ena = 1'b1;
    tick();
    chk("resume_req_fall", aer_req, 0);
    chk("frz_no_overflow", overflow, 0);
    aer_ack = 1'b0;
    repeat (2) begin
      tick();
      chk("resume_release", {aer_req, aer_data}, {1'b0, d});
    end
    drain();
    push(8'h01, 1'b1);
    drain();
    settle();
    for (int k = 0; k < 10; k++) begin
      push(8'($urandom_range(0, 255)), 1'b1);
      drain();
      settle();
    end
    chk("final_overflow", overflow, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
